sprite_overlay_multi: RTL
=========================

Name: sprite_overlay_multi

Overview:
- Multi-channel sprite overlay stage for the VGA pipeline, replacing the single-tank draw/delay chain.
- Overlays up to N_SPR sprites on the incoming pixel stream and drives one shared external image ROM with 1-cycle read latency.
- Features beyond the single-tank path: per-channel orientation, a transparency key, fixed priority, frame-synchronous position shadowing, and per-frame bounding-box collision flags.
- Sits between the background/control stage and the mouse/cursor stage.

Parameters:
- N_SPR, 2, number of sprite channels (1..4).
- SPR_W, 32, sprite width in pixels (power of two).
- SPR_H, 32, sprite height in pixels (power of two; must equal SPR_W when ROT_EN=1).
- ROT_EN, 1, enables 90-degree orientation via address transform.
- TRANSP_KEY, 12'h0F0, ROM colour treated as transparent.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  10  vertical line counter.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing inputs.
- rgb_in  in  12  background colour.
- pos_x_in  in  12*N_SPR  sprite top-left X; channel i occupies bits [12i+11:12i].
- pos_y_in  in  12*N_SPR  sprite top-left Y; same packing.
- en_in  in  N_SPR  channel enable.
- dir_in  in  2*N_SPR  orientation per channel: 0 up, 1 right, 2 down, 3 left.
- pixel_addr  out  clog2(N_SPR)+clog2(SPR_W)+clog2(SPR_H)  ROM address = {channel, row, col}.
- rgb_pixel  in  12  ROM data, valid one clk after pixel_addr.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/10/1/1/1/1  timing delayed 2 clk.
- rgb_out  out  12  composited colour.
- collision_out  out  N_SPR  per-channel collision flags of the last completed frame.

Behaviour:
- Reset:
  - All outputs are 0.
  - Shadow positions, enables and directions are 0.
  - Collision accumulators are 0.
- Shadowing:
  - On a vsync_in rising edge (registered previous value 0, current 1), latch pos_x_in, pos_y_in, en_in and dir_in into shadow registers.
  - Input changes mid-frame have no effect until the next latch.
  - After reset, no sprite is drawn until the first latch.
- Hit test (stage 1, on the current pixel):
  - hit_i = shadow en_i & hc>=x_i & hc<x_i+SPR_W & vc>=y_i & vc<y_i+SPR_H.
  - Sums use 13-bit arithmetic and never wrap. Sprites that run past the visible edge are clipped naturally.
- Priority: the lowest channel index with hit_i wins. Only the winner is addressed.
- Addressing (stage 1):
  - dx = hc - x_w, dy = vc - y_w, truncated to clog2 widths.
  - Transform by dir, with S = SPR_W-1:
    - 0: (row=dy, col=dx)
    - 1: (row=S-dx, col=dy)
    - 2: (row=S-dy, col=S-dx)
    - 3: (row=dx, col=S-dy)
  - When ROT_EN=0, dir is ignored and treated as 0.
  - pixel_addr is registered. With no hit, it holds its previous value.
- Stage 1 also registers: any_hit, rgb_in and the timing signals.
- Composite (stage 2):
  - Blank (delayed hblnk|vblnk) -> rgb_out = 0.
  - Else any_hit and rgb_pixel != TRANSP_KEY -> rgb_out = rgb_pixel.
  - Else rgb_out = delayed rgb_in.
  - A transparent winner pixel shows background, never a lower-priority sprite.
- Latency: every output is exactly 2 clk after its input. Timing outputs are a pure 2-stage delay.
- Collision:
  - On a non-blank pixel where two or more hit_i are set, set acc_i for every hitting channel.
  - On the latch edge, collision_out <= acc, and acc clears in the same cycle.
  - A collision on the latch cycle itself is counted in the new frame.
- Reset mid-frame: everything clears immediately. Output resumes as pure background until the next vsync latch.

Decomposition:
- Shared package holds: the colour type (12 bit), the timing-bundle width constants, the dir encodings (DIR_UP/RIGHT/DOWN/LEFT) and TRANSP_KEY's default.
- One natural sub-module: sprite_hit_unit.
  - Instantiated once per channel.
  - Holds the shadow registers and the bounds compare; outputs hit, dx, dy and dir.
- The priority mux, address transform, composite and collision logic stay in the top module.

Test Plan:
- Reset release, then 2 frames with en_in=0 -> rgb_out equals rgb_in delayed 2 clk; all outputs 0 during reset; collision_out = 0.
- Ch0 at (100,50), dir 0, en 1 -> at pixel (100,50) pixel_addr = {0,0,0}; at (131,81) = {0,31,31}; at (132,50) no hit; rgb_out = ROM data 2 clk later.
- Ch0 dir 1, pixel (100+5, 50+3) -> row=26, col=3; dir 2 -> row=28, col=26; dir 3 -> row=5, col=28.
- ROM returns 12'h0F0 in sprite area -> rgb_out = rgb_in; during hblnk inside the sprite box -> rgb_out = 0.
- Ch0 at (100,50) and ch1 at (120,60), both enabled -> overlap region shows ch0; after the next vsync rising edge collision_out = 2'b11; move them apart -> one frame later 2'b00.
- Change pos_x_in mid-frame -> drawn position unchanged until the next vsync edge; assert rst mid-line -> outputs 0 asynchronously, no sprite until a vsync latch.

Source files
------------

// File: rtl/sprite_overlay_multi_pkg.sv
// sprite_overlay_multi_pkg: shared types and constants for the sprite overlay stage
package sprite_overlay_multi_pkg;
  typedef logic [11:0] color_t;
  localparam int HC_W = 11;
  localparam int VC_W = 10;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;
  localparam color_t TRANSP_KEY_DEF = 12'h0F0;
  typedef struct packed {
    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } timing_t;
endpackage

// File: rtl/sprite_overlay_multi_if.sv
// sprite_overlay_multi_if: shared image ROM port (address out, data back one clk later)
interface sprite_overlay_multi_if import sprite_overlay_multi_pkg::*; #(parameter int AW = 11);
  logic [AW-1:0] pixel_addr;
  color_t rgb_pixel;
  modport master (output pixel_addr, input rgb_pixel);
  modport slave (input pixel_addr, output rgb_pixel);
endinterface

// File: rtl/sprite_overlay_multi_sprite_hit_unit.sv
// sprite_hit_unit: per-channel frame-shadowed position and bounding-box hit test
module sprite_hit_unit import sprite_overlay_multi_pkg::*; #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int XW = $clog2(SPR_W),
  parameter int YW = $clog2(SPR_H)
) (
  input  logic clk,
  input  logic rst,
  input  logic latch,
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  input  logic en,
  input  dir_t dir,
  input  logic [HC_W-1:0] hc,
  input  logic [VC_W-1:0] vc,
  output logic hit,
  output logic [XW-1:0] dx,
  output logic [YW-1:0] dy,
  output dir_t dir_s
);
  logic [11:0] sx, sy;
  logic en_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sx <= '0;
      sy <= '0;
      en_s <= 1'b0;
      dir_s <= DIR_UP;
    end else if (latch) begin
      sx <= pos_x;
      sy <= pos_y;
      en_s <= en;
      dir_s <= dir;
    end
  // 13-bit compares so a sprite near 4095 never wraps back onto the screen
  assign hit = en_s && 13'(hc) >= {1'b0, sx} && 13'(hc) < {1'b0, sx} + 13'(SPR_W)
                    && 13'(vc) >= {1'b0, sy} && 13'(vc) < {1'b0, sy} + 13'(SPR_H);
  assign dx = XW'(13'(hc) - {1'b0, sx});
  assign dy = YW'(13'(vc) - {1'b0, sy});
endmodule

// File: rtl/sprite_overlay_multi.sv
// sprite_overlay_multi: overlays N_SPR prioritised, rotatable sprites from a shared ROM onto the pixel stream
module sprite_overlay_multi import sprite_overlay_multi_pkg::*; #(
  parameter int N_SPR = 2,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter bit ROT_EN = 1'b1,
  parameter color_t TRANSP_KEY = TRANSP_KEY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic [HC_W-1:0] hcount_in,
  input  logic [VC_W-1:0] vcount_in,
  input  logic hsync_in,
  input  logic vsync_in,
  input  logic hblnk_in,
  input  logic vblnk_in,
  input  color_t rgb_in,
  input  logic [12*N_SPR-1:0] pos_x_in,
  input  logic [12*N_SPR-1:0] pos_y_in,
  input  logic [N_SPR-1:0] en_in,
  input  logic [2*N_SPR-1:0] dir_in,
  sprite_overlay_multi_if.master rom,
  output logic [HC_W-1:0] hcount_out,
  output logic [VC_W-1:0] vcount_out,
  output logic hsync_out,
  output logic vsync_out,
  output logic hblnk_out,
  output logic vblnk_out,
  output color_t rgb_out,
  output logic [N_SPR-1:0] collision_out
);
  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int CW = $clog2(N_SPR);
  localparam int WW = (CW > 0) ? CW : 1;
  localparam int AW = CW + XW + YW;
  localparam logic [XW-1:0] SX = XW'(SPR_W - 1);
  localparam logic [YW-1:0] SY = YW'(SPR_W - 1);
  logic vs_prev, latch, any, any1, any2, coll;
  logic [N_SPR-1:0] hit, acc;
  logic [N_SPR-1:0][XW-1:0] dx_a;
  logic [N_SPR-1:0][YW-1:0] dy_a;
  dir_t [N_SPR-1:0] dir_a;
  logic [WW-1:0] win;
  logic [XW-1:0] dx_w, col;
  logic [YW-1:0] dy_w, row;
  dir_t dir_w, d;
  color_t rgb1, rgb2;
  timing_t t_in, t1, t2;
  assign latch = vsync_in & ~vs_prev;
  assign t_in = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = t2;
  for (genvar i = 0; i < N_SPR; i++) begin : g_ch
    sprite_hit_unit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .clk(clk), .rst(rst), .latch(latch),
      .pos_x(pos_x_in[12*i +: 12]), .pos_y(pos_y_in[12*i +: 12]),
      .en(en_in[i]), .dir(dir_t'(dir_in[2*i +: 2])),
      .hc(hcount_in), .vc(vcount_in),
      .hit(hit[i]), .dx(dx_a[i]), .dy(dy_a[i]), .dir_s(dir_a[i])
    );
  end
  // descending scan so the lowest hitting index is the one left standing
  always_comb begin
    win = '0;
    any = 1'b0;
    dx_w = '0;
    dy_w = '0;
    dir_w = DIR_UP;
    for (int i = N_SPR - 1; i >= 0; i--)
      if (hit[i]) begin
        win = WW'(i);
        any = 1'b1;
        dx_w = dx_a[i];
        dy_w = dy_a[i];
        dir_w = dir_a[i];
      end
  end
  assign d = ROT_EN ? dir_w : DIR_UP;
  assign row = d == DIR_UP ? dy_w : d == DIR_RIGHT ? YW'(SX - dx_w) : d == DIR_DOWN ? SY - dy_w : YW'(dx_w);
  assign col = d == DIR_UP ? dx_w : d == DIR_RIGHT ? XW'(dy_w) : d == DIR_DOWN ? SX - dx_w : XW'(SY - dy_w);
  assign coll = ((hit & (hit - 1'b1)) != '0) && !(hblnk_in || vblnk_in);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_prev <= 1'b0;
      t1 <= '0;
      t2 <= '0;
      any1 <= 1'b0;
      any2 <= 1'b0;
      rgb1 <= '0;
      rgb2 <= '0;
      rom.pixel_addr <= '0;
      acc <= '0;
      collision_out <= '0;
    end else begin
      vs_prev <= vsync_in;
      t1 <= t_in;
      t2 <= t1;
      any1 <= any;
      any2 <= any1;
      rgb1 <= rgb_in;
      rgb2 <= rgb1;
      if (any) rom.pixel_addr <= AW'({win, row, col});
      acc <= (latch ? '0 : acc) | (coll ? hit : '0);
      if (latch) collision_out <= acc;
    end
  // ROM data arrives with stage 2, so the final select is combinational on it
  assign rgb_out = (hblnk_out || vblnk_out) ? '0
                 : (any2 && rom.rgb_pixel != TRANSP_KEY) ? rom.rgb_pixel : rgb2;
endmodule
